// File: rtl/timer_pkg.sv
// Shared definitions for the timer_1ms timebase: LFSR geometry, constant
// functions used at elaboration, and the cycles-per-tick helper.
package timer_pkg;

  localparam int LFSR_W = 16;

  typedef logic [LFSR_W-1:0] lfsr_t;

  // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form).
  localparam lfsr_t LFSR_MASK = 16'hB400;
  localparam lfsr_t LFSR_SEED = 16'h0001;

  // One step of the right-shifting Galois LFSR.
  function automatic lfsr_t lfsr_next(input lfsr_t s);
    lfsr_t nxt;
    nxt = s >> 1;
    if (s[0]) begin
      nxt = nxt ^ LFSR_MASK;
    end
    return nxt;
  endfunction

  // LFSR state reached after n steps from the seed; used to find the
  // terminal state that corresponds to a binary count of n.
  function automatic lfsr_t lfsr_state_after(input int unsigned n);
    lfsr_t s;
    s = LFSR_SEED;
    for (int unsigned i = 0; i < n; i++) begin
      s = lfsr_next(s);
    end
    return s;
  endfunction

  // Number of system clocks in one tick period.
  function automatic int unsigned cycles_per_tick(input int unsigned clk_freq_hz,
                                                  input int unsigned period_us);
    return clk_freq_hz / 1_000_000 * period_us;
  endfunction

endpackage

// File: rtl/timer_1ms_lfsr16.sv
// 16-bit Galois LFSR used as the period counter when TIMER_1MS_LFSR_EN is
// defined. Reset and load_seed both return it to the seed; advance steps it.
module lfsr16
  import timer_pkg::*;
(
  input  logic  Clk,
  input  logic  Rst,
  input  logic  load_seed,
  input  logic  advance,
  output lfsr_t state
);

  // Seed on reset or reload request, otherwise step when asked to advance.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= LFSR_SEED;
    end else if (load_seed) begin
      state <= LFSR_SEED;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/timer_1ms.sv
// Periodic one-cycle Tick strobe, once every CYCLES enabled clocks.
// Default build uses a binary up-counter; defining TIMER_1MS_LFSR_EN swaps in
// a 16-bit LFSR counter (lfsr16) with identical Tick timing.
// Dropping Enable restarts the period from the beginning.
module timer_1ms
  import timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned TICK_PERIOD_US = 1000
) (
  input  logic Enable,
  output logic Tick,
  input  logic Clk,
  input  logic Rst
);

  localparam int unsigned CYCLES = cycles_per_tick(CLK_FREQ_HZ, TICK_PERIOD_US);
  localparam int unsigned CNT_W  = $clog2(CYCLES);

  if (CYCLES < 2) begin : g_bad_cycles
    $error("timer_1ms: CYCLES must be at least 2");
  end

  logic at_terminal;

`ifdef TIMER_1MS_LFSR_EN

  localparam lfsr_t TERMINAL = lfsr_state_after(CYCLES - 1);

  lfsr_t lfsr_state;

  if (CYCLES > 65535 || CNT_W > LFSR_W) begin : g_bad_lfsr_len
    $error("timer_1ms: LFSR mode supports at most 65535 cycles per tick");
  end

  assign at_terminal = (lfsr_state == TERMINAL);

  lfsr16 u_lfsr (
    .Clk       (Clk),
    .Rst       (Rst),
    .load_seed (!Enable || at_terminal),
    .advance   (Enable && !at_terminal),
    .state     (lfsr_state)
  );

`else

  logic [CNT_W-1:0] count;

  assign at_terminal = (count == CNT_W'(CYCLES - 1));

  // Binary period counter: wraps at the terminal value, restarts when disabled.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count <= '0;
    end else if (!Enable || at_terminal) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

`endif

  // Tick fires on the edge where the counter wraps, only while enabled.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Tick <= 1'b0;
    end else begin
      Tick <= Enable && at_terminal;
    end
  end

endmodule

// File: tb/tb_timer_1ms.sv
// Scoreboard bench for timer_1ms: two scaled instances (10 and 4 cycles per
// tick) share Enable/Rst. The stimulus pushes the expected Tick pair for each
// edge; a monitor pops and compares one entry after every rising edge.
module tb_timer_1ms;

  localparam int C10 = 10;
  localparam int C4  = 4;

  logic Clk = 1'b0;
  logic Rst;
  logic Enable;
  logic tick10;
  logic tick4;

  typedef struct packed {
    logic t10;
    logic t4;
  } exp_t;

  typedef struct {
    logic rst;
    logic en;
    int   n;
  } seg_t;

  exp_t exp_q[$];
  int   assertions = 0;
  int   failures   = 0;
  int   run_len    = 0;
  int   ticks10    = 0;
  int   ticks4     = 0;

  // Directed segments: {Rst, Enable, cycles}. Totals hand-computed:
  // dut10 ticks 10+2+1+2+1+2 = 18, dut4 ticks 25+1+6+2+2+5+2+3+5 = 51.
  seg_t segs [17] = '{
    '{1'b1, 1'b0,   3},
    '{1'b0, 1'b1, 100},
    '{1'b0, 1'b0,   1},
    '{1'b0, 1'b1,   6},
    '{1'b0, 1'b0,   5},
    '{1'b0, 1'b1,  25},
    '{1'b0, 1'b0,   1},
    '{1'b0, 1'b1,   9},
    '{1'b0, 1'b0,   1},
    '{1'b0, 1'b1,  10},
    '{1'b0, 1'b0,   1},
    '{1'b0, 1'b1,  20},
    '{1'b1, 1'b0,   2},
    '{1'b0, 1'b1,   8},
    '{1'b1, 1'b0,   1},
    '{1'b0, 1'b1,  12},
    '{1'b0, 1'b1,  20}
  };

  timer_1ms #(.CLK_FREQ_HZ(10_000_000), .TICK_PERIOD_US(1)) dut10 (
    .Enable (Enable),
    .Tick   (tick10),
    .Clk    (Clk),
    .Rst    (Rst)
  );

  timer_1ms #(.CLK_FREQ_HZ(4_000_000), .TICK_PERIOD_US(1)) dut4 (
    .Enable (Enable),
    .Tick   (tick4),
    .Clk    (Clk),
    .Rst    (Rst)
  );

  always #10 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en);
    exp_t e;
    @(negedge Clk);
    Rst    = rst;
    Enable = en;
    if (rst || !en) begin
      run_len = 0;
    end else begin
      run_len++;
    end
    e.t10 = (run_len != 0) && (run_len % C10 == 0);
    e.t4  = (run_len != 0) && (run_len % C4 == 0);
    exp_q.push_back(e);
  endtask

  // Synchronous monitor: one scoreboard entry per rising edge.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("tick10", {31'b0, tick10}, {31'b0, e.t10});
        checkOutput("tick4", {31'b0, tick4}, {31'b0, e.t4});
        if (tick10 === 1'b1) ticks10++;
        if (tick4 === 1'b1) ticks4++;
      end
    end
  end

  // Asynchronous reset monitor: Tick must clear without waiting for a clock.
  initial begin
    forever begin
      @(posedge Rst);
      #1;
      checkOutput("async_rst_tick10", {31'b0, tick10}, 32'd0);
      checkOutput("async_rst_tick4", {31'b0, tick4}, 32'd0);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Rst    = 1'b1;
    Enable = 1'b0;
    for (int s = 0; s < 17; s++) begin
      for (int k = 0; k < segs[s].n; k++) begin
        applyStimulus(segs[s].rst, segs[s].en);
      end
    end
    repeat (2) @(negedge Clk);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    checkOutput("total_ticks10", ticks10, 32'd18);
    checkOutput("total_ticks4", ticks4, 32'd51);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/timer_1ms.md
# timer_1ms

Periodic tick generator producing a single-cycle strobe every 1 ms of the system clock. It is the game's base timebase: downstream blocks (display refresh, movement, scoring) count its ticks instead of raw clocks. The counter is either a plain binary counter or, optionally, an LFSR-based counter for lower logic depth.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: system clock frequency (20 ns period).
- `TICK_PERIOD_US`, default 1000: tick period in microseconds.
- `CYCLES` (localparam): `CLK_FREQ_HZ/1_000_000*TICK_PERIOD_US`, 50_000 by default. Must be ≥ 2; elaboration error otherwise.
- `CNT_W` (localparam): `$clog2(CYCLES)`, 16 by default.
- One clock; reset is asynchronous and active-high.
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Rst`  in  1  asynchronous active-high reset.
- `Enable`  in  1  count enable, sampled synchronously.
- `Tick`  out  1  registered one-cycle strobe, once per `CYCLES` enabled clocks.
- Positional port order is fixed: `Enable`, `Tick`, `Clk`, `Rst`.

## Operation
- Reset (async, while `Rst`=1): count register = 0 (LFSR mode: seed 16'h0001), `Tick`=0.
- On each rising edge with `Enable`=1:
  - If count is at terminal value: reload start value and set `Tick`=1.
  - Otherwise: advance count and set `Tick`=0.
- Terminal value is `CYCLES-1` in binary mode, or the precomputed LFSR state in LFSR mode.
- On each rising edge with `Enable`=0: count reloads its start value and `Tick`=0.
  - Disabling therefore restarts the period; no partial progress is kept.
- `Tick` is never high for two consecutive cycles (`CYCLES` ≥ 2).
- Binary count never exceeds `CYCLES-1`. Wrap-around from terminal to start happens in the same edge that raises `Tick`.

## Timing
- Let edge 1 be the first rising edge with `Rst`=0 and `Enable`=1.
- `Tick` rises after edge `CYCLES` (edge 50_000 by default). It stays high exactly one cycle and falls after edge `CYCLES+1`.
- Steady state: one `Tick` every `CYCLES` clocks, i.e. 1.000 ms at 50 MHz. No drift.
- `Enable` deasserted in the same cycle `Tick` would fire: no tick, counter restarts.
- `Rst` asserted mid-period: `Tick` and count clear immediately, without waiting for a clock. Counting resumes from the start value on the first enabled edge after release.
- Latency from `Enable` rising to first `Tick`: exactly `CYCLES` clocks.

## Configuration
- Macro `TIMER_1MS_LFSR_EN`.
- Defined:
  - The count register is a 16-bit maximal-length Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400), seeded 16'h0001.
  - The terminal state is the LFSR state after `CYCLES-1` steps from the seed, computed at elaboration by a constant function.
  - Requires `CYCLES` ≤ 65535; elaboration error otherwise.
  - The all-zero state is unreachable.
- Not defined: binary up-counter of width `CNT_W`.
- `Tick` timing is cycle-identical in both modes.

## Structure
- Shared package `timer_pkg` holds:
  - the LFSR width (16), mask 16'hB400 and seed 16'h0001;
  - the constant function `lfsr_state_after(n)`;
  - the helper computing `CYCLES` from the frequency and period.
- One sub-module, `lfsr16`: next-state logic with synchronous load-seed and advance inputs, and async reset to the seed. It is instantiated only under `TIMER_1MS_LFSR_EN`.

## Test plan
- Reset, then `Enable`=1 from edge 1 → `Tick`=1 only after edge 50_000, low after edge 50_001; next rise after edge 100_000.
- Run 10 ms → exactly 10 ticks, spaced 50_000 cycles apart, each one cycle wide.
- Deassert `Enable` at count 30_000 for 5 cycles, then reassert → no tick. First tick lands 50_000 enabled edges after reassertion.
- Pulse `Rst` at count 49_998 (between edges) → `Tick` and count clear immediately; no tick at the old boundary.
- Override `CLK_FREQ_HZ`=4_000_000 and `TICK_PERIOD_US`=1 (`CYCLES`=4) → `Tick` pattern 0,0,0,1 repeating.
- Rerun all scenarios with `TIMER_1MS_LFSR_EN` defined → identical `Tick` waveform.
